regfile_sequencer: RTL

// Initiator/controller for the 16x16 register file (rs/rt read, rd/RegWrite write).

---
 rtl/regfile_sequencer.sv | 129 ++++++++++++
 1 files changed

// File: rtl/regfile_sequencer.sv
// Multi-cycle controller for the 16x16 register file: accepts one R-type instruction,
// reads rs/rt, computes the ALU result and issues a single write-back to rd.
module regfile_sequencer #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [15:0]           in_instr,
    output logic [ADDR_WIDTH-1:0] rf_rs,
    output logic [ADDR_WIDTH-1:0] rf_rt,
    output logic [ADDR_WIDTH-1:0] rf_rd,
    output logic [DATA_WIDTH-1:0] rf_data,
    output logic                  rf_RegWrite,
    input  logic [DATA_WIDTH-1:0] rf_out1,
    input  logic [DATA_WIDTH-1:0] rf_out2,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  ovf,
    output logic                  err,
    output logic                  done,
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, READ, EXEC, WRITE} state_t;

    localparam logic [3:0] OP_NOP = 4'h0, OP_ADD = 4'h1, OP_SUB = 4'h2, OP_AND = 4'h3,
                           OP_OR  = 4'h4, OP_XOR = 4'h5, OP_NOR = 4'h6, OP_SLT = 4'h7,
                           OP_SLL = 4'h8, OP_SRL = 4'h9, OP_MOV = 4'hA;

    state_t                state;
    logic [15:0]           instr;
    logic [DATA_WIDTH-1:0] a, b;

    logic [DATA_WIDTH-1:0] alu_res;
    logic                  alu_ovf, alu_wen, alu_ill;
    logic [3:0]            op;

    assign op      = instr[15:12];
    assign rf_rs   = instr[11:8];
    assign rf_rt   = instr[7:4];
    assign rf_rd   = instr[3:0];
    assign rf_data = result;

    always_comb begin
        alu_res = result;
        alu_ovf = 1'b0;
        alu_wen = 1'b1;
        alu_ill = 1'b0;
        case (op)
            OP_NOP: alu_wen = 1'b0;
            OP_ADD: begin
                alu_res = a + b;
                alu_ovf = (a[DATA_WIDTH-1] == b[DATA_WIDTH-1]) &&
                          (alu_res[DATA_WIDTH-1] != a[DATA_WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = a - b;
                alu_ovf = (a[DATA_WIDTH-1] != b[DATA_WIDTH-1]) &&
                          (alu_res[DATA_WIDTH-1] != a[DATA_WIDTH-1]);
            end
            OP_AND: alu_res = a & b;
            OP_OR:  alu_res = a | b;
            OP_XOR: alu_res = a ^ b;
            OP_NOR: alu_res = ~(a | b);
            OP_SLT: alu_res = ($signed(a) < $signed(b)) ? DATA_WIDTH'(1) : '0;
            OP_SLL: alu_res = a << b[3:0];
            OP_SRL: alu_res = a >> b[3:0];
            OP_MOV: alu_res = a;
            default: begin
                alu_wen = 1'b0;
                alu_ill = 1'b1;
            end
        endcase
    end

    // in_ready is registered, so the first IDLE cycle after reset still shows 0.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            instr       <= '0;
            a           <= '0;
            b           <= '0;
            result      <= '0;
            ovf         <= 1'b0;
            err         <= 1'b0;
            done        <= 1'b0;
            busy        <= 1'b0;
            rf_RegWrite <= 1'b0;
            in_ready    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        instr    <= in_instr;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= READ;
                    end
                end
                READ: begin
                    a     <= rf_out1;
                    b     <= rf_out2;
                    state <= EXEC;
                end
                EXEC: begin
                    result      <= alu_res;
                    ovf         <= alu_ovf;
                    err         <= alu_ill;
                    rf_RegWrite <= alu_wen;
                    done        <= 1'b1;
                    state       <= WRITE;
                end
                WRITE: begin
                    rf_RegWrite <= 1'b0;
                    done        <= 1'b0;
                    err         <= 1'b0;
                    busy        <= 1'b0;
                    in_ready    <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
